// File: rtl/aes_pkg.sv
// Shared AES-128 key schedule definitions: word/key types, Rcon table and S-box table.
package aes_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] key_t;

  localparam int RCON_BASE_DEFAULT = 3;

  // Rcon bytes for index 0..9, index 0 in the least significant byte
  localparam logic [79:0] RCON_TABLE = 80'h361B8040201008040201;

  // Forward S-box, entry 0x00 in the most significant byte
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic word_t rcon_word(input logic [3:0] idx);
    word_t w;
    w = '0;
    if (idx <= 4'd9) begin
      w[31:24] = RCON_TABLE[{idx, 3'b000} +: 8];
    end
    return w;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box lookup for one byte.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] value,
  output logic [7:0] result
);

  // Entry n sits (255 - n) bytes up from bit 0, i.e. at bit offset {~n, 3'b000}
  assign result = SBOX_TABLE[{~value, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_expansion.sv
// Single-step AES-128 key schedule: next round key (forward) or previous round key (inverse).
// Optional KEYEXP_ROUND_CHECK_EN adds o_RoundErr flagging an out-of-range round index.
module aes_key_expansion
  import aes_pkg::*;
#(
  parameter int RCON_BASE = RCON_BASE_DEFAULT
)
(
  input  logic         Clk,
  input  logic         Rst,
  input  logic [127:0] i_Key,
  input  logic [3:0]   i_Round,
  input  logic         i_fDec,
  input  logic         i_Valid,
`ifdef KEYEXP_ROUND_CHECK_EN
  output logic         o_RoundErr,
`endif
  output logic [127:0] o_Key,
  output logic         o_Valid
);

  localparam logic [4:0] ROUND_LO = 5'(RCON_BASE);
  localparam logic [4:0] ROUND_HI = 5'(RCON_BASE + 9);

  word_t      w0, w1, w2, w3;
  word_t      g_in, rot, sub, rcon, g_out;
  key_t       key_next, key_reg;
  logic       valid_reg;
  logic       in_range;
  logic [4:0] round_ext;
  logic [3:0] rcon_idx;

  assign w0 = i_Key[127:96];
  assign w1 = i_Key[95:64];
  assign w2 = i_Key[63:32];
  assign w3 = i_Key[31:0];

  assign round_ext = {1'b0, i_Round};
  assign in_range  = (round_ext >= ROUND_LO) && (round_ext <= ROUND_HI);
  assign rcon_idx  = 4'(round_ext - ROUND_LO);
  assign rcon      = in_range ? rcon_word(rcon_idx) : '0;

  // Both directions share one g(); the inverse feeds it the recovered last word k3^k2
  assign g_in = i_fDec ? (w3 ^ w2) : w3;
  assign rot  = {g_in[23:0], g_in[31:24]};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_subword
      aes_sbox u_sbox (
        .value  (rot[8*gi +: 8]),
        .result (sub[8*gi +: 8])
      );
    end
  endgenerate

  assign g_out = sub ^ rcon;

  always_comb begin
    key_next = '0;
    if (i_fDec) begin
      key_next[31:0]   = w3 ^ w2;
      key_next[63:32]  = w2 ^ w1;
      key_next[95:64]  = w1 ^ w0;
      key_next[127:96] = w0 ^ g_out;
    end else begin
      key_next[127:96] = w0 ^ g_out;
      key_next[95:64]  = w0 ^ g_out ^ w1;
      key_next[63:32]  = w0 ^ g_out ^ w1 ^ w2;
      key_next[31:0]   = w0 ^ g_out ^ w1 ^ w2 ^ w3;
    end
  end

`ifdef KEYEXP_ROUND_CHECK_EN
  logic err_reg;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      err_reg <= 1'b0;
    end else if (i_Valid) begin
      err_reg <= ~in_range;
    end
  end

  assign o_RoundErr = err_reg;
`endif

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      key_reg   <= '0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= i_Valid;
      if (i_Valid) begin
        key_reg <= key_next;
      end
    end
  end

  assign o_Key   = key_reg;
  assign o_Valid = valid_reg;

endmodule

// File: tb/tb_aes_key_expansion.sv
// Self-checking bench for aes_key_expansion: known vectors, corner sequences and a GF(2^8)-derived reference model.
module tb_aes_key_expansion;

  localparam int RCON_BASE = 3;

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic [127:0] i_Key = '0;
  logic [3:0]   i_Round = '0;
  logic         i_fDec = 1'b0;
  logic         i_Valid = 1'b0;
  logic [127:0] o_Key;
  logic         o_Valid;
`ifdef KEYEXP_ROUND_CHECK_EN
  logic         o_RoundErr;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] sbox_ref [256];

  typedef struct {
    logic [127:0] key;
    logic [3:0]   round;
    logic         dec;
    logic [127:0] expect_key;
  } vec_t;

  vec_t vecs [4];

  aes_key_expansion #(.RCON_BASE(RCON_BASE)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .i_Key      (i_Key),
    .i_Round    (i_Round),
    .i_fDec     (i_fDec),
    .i_Valid    (i_Valid),
`ifdef KEYEXP_ROUND_CHECK_EN
    .o_RoundErr (o_RoundErr),
`endif
    .o_Key      (o_Key),
    .o_Valid    (o_Valid)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---- reference model built from GF(2^8) arithmetic ----
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv, r, s;
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      s = inv;
      r = inv;
      for (int k = 0; k < 4; k++) begin
        r = {r[6:0], r[7]};
        s = s ^ r;
      end
      sbox_ref[a] = s ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] rcon_ref(input int round);
    logic [7:0] c;
    if (round < RCON_BASE || round > RCON_BASE + 9) return 32'h0;
    c = 8'h01;
    for (int i = RCON_BASE; i < round; i++) c = xtime(c);
    return {c, 24'h0};
  endfunction

  function automatic logic [31:0] g_ref(input logic [31:0] w, input int round);
    logic [7:0] b [4];
    logic [31:0] r;
    for (int i = 0; i < 4; i++) b[i] = w[31 - 8*i -: 8];
    r = {sbox_ref[b[1]], sbox_ref[b[2]], sbox_ref[b[3]], sbox_ref[b[0]]};
    return r ^ rcon_ref(round);
  endfunction

  function automatic logic [127:0] key_ref(input logic [127:0] key, input int round, input logic dec);
    logic [31:0] k [4];
    logic [31:0] n [4];
    for (int i = 0; i < 4; i++) k[i] = key[127 - 32*i -: 32];
    if (!dec) begin
      n[0] = k[0] ^ g_ref(k[3], round);
      for (int i = 1; i < 4; i++) n[i] = n[i-1] ^ k[i];
    end else begin
      n[3] = k[3] ^ k[2];
      n[2] = k[2] ^ k[1];
      n[1] = k[1] ^ k[0];
      n[0] = k[0] ^ g_ref(n[3], round);
    end
    return {n[0], n[1], n[2], n[3]};
  endfunction

  // Drive one cycle of inputs, let one rising edge pass, sample 1 time unit later
  task automatic apply(input logic [127:0] key, input logic [3:0] round, input logic dec, input logic valid);
    i_Key   = key;
    i_Round = round;
    i_fDec  = dec;
    i_Valid = valid;
    @(posedge Clk);
    #1;
    $display("step key=%h round=%0d dec=%0b valid=%0b -> o_Key=%h o_Valid=%0b",
             key, round, dec, valid, o_Key, o_Valid);
  endtask

  initial begin
    logic [127:0] exp_key, rkey;
    logic [3:0]   rround;
    logic         rdec, rvalid;

    vecs[0] = '{128'h5468617473206D79204B756E67204675, 4'd3, 1'b0, 128'hE232FCF191129188B159E4E6D679A293};
    vecs[1] = '{128'hE232FCF191129188B159E4E6D679A293, 4'd4, 1'b0, 128'h56082007C71AB18F76435569A03AF7FA};
    vecs[2] = '{128'hE232FCF191129188B159E4E6D679A293, 4'd3, 1'b1, 128'h5468617473206D79204B756E67204675};
    vecs[3] = '{128'h56082007C71AB18F76435569A03AF7FA, 4'd4, 1'b1, 128'hE232FCF191129188B159E4E6D679A293};

    build_sbox();

    // Reset state, held through clock edges even with a valid step offered
    #1;
    check("reset_key", o_Key, 128'h0);
    check("reset_valid", {127'h0, o_Valid}, 128'h0);
    apply(vecs[0].key, vecs[0].round, vecs[0].dec, 1'b1);
    check("reset_hold_key", o_Key, 128'h0);
    check("reset_hold_valid", {127'h0, o_Valid}, 128'h0);
    Rst = 1'b0;
    i_Valid = 1'b0;
    @(posedge Clk);
    #1;
    check("post_reset_idle_valid", {127'h0, o_Valid}, 128'h0);

    // Known vectors from the table, applied back-to-back
    for (int v = 0; v < 4; v++) begin
      apply(vecs[v].key, vecs[v].round, vecs[v].dec, 1'b1);
      check($sformatf("vec%0d_key", v), o_Key, vecs[v].expect_key);
      check($sformatf("vec%0d_valid", v), {127'h0, o_Valid}, 128'h1);
      check($sformatf("vec%0d_model", v), o_Key,
            key_ref(vecs[v].key, int'(vecs[v].round), vecs[v].dec));
    end

    // Two forward steps on consecutive cycles, then idle hold
    apply(vecs[0].key, vecs[0].round, 1'b0, 1'b1);
    check("b2b_first", o_Key, 128'hE232FCF191129188B159E4E6D679A293);
    apply(vecs[1].key, vecs[1].round, 1'b0, 1'b1);
    check("b2b_second", o_Key, 128'h56082007C71AB18F76435569A03AF7FA);
    check("b2b_second_valid", {127'h0, o_Valid}, 128'h1);
    apply(128'h0123456789ABCDEF0123456789ABCDEF, 4'd7, 1'b1, 1'b0);
    check("idle_hold_key", o_Key, 128'h56082007C71AB18F76435569A03AF7FA);
    check("idle_valid", {127'h0, o_Valid}, 128'h0);
    apply(128'h0, 4'd0, 1'b0, 1'b0);
    check("idle_hold_key2", o_Key, 128'h56082007C71AB18F76435569A03AF7FA);

    // Out-of-range and boundary round indices
    apply(vecs[0].key, 4'd0, 1'b0, 1'b1);
    check("round0_key", o_Key, key_ref(vecs[0].key, 0, 1'b0));
`ifdef KEYEXP_ROUND_CHECK_EN
    check("round0_err", {127'h0, o_RoundErr}, 128'h1);
`endif
    apply(vecs[0].key, 4'd12, 1'b0, 1'b1);
    check("round12_key", o_Key, key_ref(vecs[0].key, 12, 1'b0));
`ifdef KEYEXP_ROUND_CHECK_EN
    check("round12_err", {127'h0, o_RoundErr}, 128'h0);
`endif
    apply(vecs[0].key, 4'd13, 1'b1, 1'b1);
    check("round13_key", o_Key, key_ref(vecs[0].key, 13, 1'b1));
    apply(vecs[0].key, 4'd2, 1'b0, 1'b1);
    check("round2_key", o_Key, key_ref(vecs[0].key, 2, 1'b0));
`ifdef KEYEXP_ROUND_CHECK_EN
    check("round2_err", {127'h0, o_RoundErr}, 128'h1);
`endif

    // Asynchronous reset mid-cycle discards the pending step
    i_Key = vecs[1].key;
    i_Round = 4'd4;
    i_fDec = 1'b0;
    i_Valid = 1'b1;
    #2;
    Rst = 1'b1;
    #1;
    check("async_rst_key", o_Key, 128'h0);
    check("async_rst_valid", {127'h0, o_Valid}, 128'h0);
    @(posedge Clk);
    #1;
    check("rst_discard_key", o_Key, 128'h0);
    i_Valid = 1'b0;
    Rst = 1'b0;
    @(posedge Clk);
    #1;
    check("rst_release_key", o_Key, 128'h0);
    check("rst_release_valid", {127'h0, o_Valid}, 128'h0);
    apply(vecs[2].key, vecs[2].round, 1'b1, 1'b1);
    check("first_capture_key", o_Key, vecs[2].expect_key);

    // Randomized steps against the reference model
    exp_key = o_Key;
    for (int t = 0; t < 60; t++) begin
      rkey   = {$urandom, $urandom, $urandom, $urandom};
      rround = 4'($urandom_range(0, 15));
      rdec   = 1'($urandom_range(0, 1));
      rvalid = ($urandom_range(0, 3) != 0);
      if (rvalid) exp_key = key_ref(rkey, int'(rround), rdec);
      apply(rkey, rround, rdec, rvalid);
      check($sformatf("rand%0d_key", t), o_Key, exp_key);
      check($sformatf("rand%0d_valid", t), {127'h0, o_Valid}, {127'h0, rvalid});
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
